imm_gen_arbiter: RTL and testbench

- Shares the single immediate-generator instance between NUM_REQ requesters, e.g. decode (req 0) and branch pre-decode (req 1).
- Round-robin arbitration with one grant per cycle, valid/ready on both request and response sides.
- Drives the generator's inst/imm_type inputs from the granted requester.
- Captures the generator output into a one-entry response slot per requester.

---
 rtl/imm_gen_arbiter_if.sv | 28 ++
 rtl/imm_gen_arbiter.sv | 51 +++++
 tb/tb_imm_gen_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/imm_gen_arbiter_if.sv
// imm_gen_arbiter_if: request, generator and response-slot signals of the shared immediate generator
interface imm_gen_arbiter_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int INST_WIDTH   = 32,
  parameter int IMM_TYPE_NUM = 4,
  parameter int NUM_REQ      = 2
);
  localparam int TW = $clog2(IMM_TYPE_NUM);
  logic                          flush;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*INST_WIDTH-1:0] req_inst;
  logic [NUM_REQ*TW-1:0]         req_imm_type;
  logic [INST_WIDTH-1:0]         gen_inst;
  logic [TW-1:0]                 gen_imm_type;
  logic [DATA_WIDTH-1:0]         gen_imm;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [NUM_REQ-1:0]            resp_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] resp_imm;
  modport master (
    output flush, req_valid, req_inst, req_imm_type, gen_imm, resp_ready,
    input  req_ready, gen_inst, gen_imm_type, resp_valid, resp_imm
  );
  modport slave (
    input  flush, req_valid, req_inst, req_imm_type, gen_imm, resp_ready,
    output req_ready, gen_inst, gen_imm_type, resp_valid, resp_imm
  );
endinterface

// File: rtl/imm_gen_arbiter.sv
// imm_gen_arbiter: round-robin sharing of one immediate generator with a one-entry response slot per requester
module imm_gen_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int INST_WIDTH   = 32,
  parameter int IMM_TYPE_NUM = 4,
  parameter int NUM_REQ      = 2
) (
  input logic              clk,
  input logic              rst,
  imm_gen_arbiter_if.slave bus
);
  localparam int TW = $clog2(IMM_TYPE_NUM);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {EMPTY, FULL} slot_e;
  slot_e                         r_slot [NUM_REQ];
  logic [PW-1:0]                 r_rr_ptr;
  logic [NUM_REQ*DATA_WIDTH-1:0] r_imm;
  logic [NUM_REQ-1:0]            w_full;
  logic [NUM_REQ-1:0]            w_elig;
  logic [NUM_REQ-1:0]            w_grant;
  logic [PW-1:0]                 w_gidx;
  logic                          w_any;
  // a full slot draining this cycle can take a new result at once
  assign w_elig = bus.req_valid & (~w_full | bus.resp_ready) & {NUM_REQ{~bus.flush & ~rst}};
  always_comb begin
    w_gidx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_elig[(int'(r_rr_ptr) + k) % NUM_REQ]) w_gidx = PW'((int'(r_rr_ptr) + k) % NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) w_full[i] = (r_slot[i] == FULL);
  end
  assign w_any            = |w_elig;
  assign w_grant          = w_any ? NUM_REQ'(1) << w_gidx : '0;
  assign bus.req_ready    = w_grant;
  assign bus.gen_inst     = w_any ? bus.req_inst[int'(w_gidx)*INST_WIDTH +: INST_WIDTH] : '0;
  assign bus.gen_imm_type = w_any ? bus.req_imm_type[int'(w_gidx)*TW +: TW] : '0;
  assign bus.resp_valid   = w_full;
  assign bus.resp_imm     = r_imm;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_imm    <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_slot[i] <= EMPTY;
    end else begin
      if (w_any) r_rr_ptr <= (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) r_imm[i*DATA_WIDTH +: DATA_WIDTH] <= bus.gen_imm;
        r_slot[i] <= (bus.flush || !(w_grant[i] || (w_full[i] && !bus.resp_ready[i]))) ? EMPTY : FULL;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_arbiter.sv
// tb_imm_gen_arbiter: directed vector table against a behavioural RISC-V immediate generator
module tb_imm_gen_arbiter;
  localparam logic [31:0] IA = 32'hFFF00093;
  localparam logic [31:0] UA = 32'h123450B7;
  localparam logic [31:0] BB = 32'hFE000EE3;
  localparam logic [31:0] SA = 32'h00112423;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MU = 64'h0000_0000_1234_5000;
  localparam logic [63:0] MB = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] MS = 64'h0000_0000_0000_0008;
  typedef struct {
    logic        rst, flush;
    logic [1:0]  rv, rr;
    logic [31:0] i0;
    logic [1:0]  t0;
    logic [31:0] i1;
    logic [1:0]  t1;
    logic [1:0]  exp_rdy, exp_vld;
    logic        c0;
    logic [63:0] m0;
    logic        c1;
    logic [63:0] m1;
  } vec_t;
  logic clk = 0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  imm_gen_arbiter_if bus ();
  imm_gen_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.gen_imm = '0;
    case (bus.gen_imm_type)
      2'd0: bus.gen_imm = {{52{bus.gen_inst[31]}}, bus.gen_inst[31:20]};
      2'd1: bus.gen_imm = {{52{bus.gen_inst[31]}}, bus.gen_inst[31:25], bus.gen_inst[11:7]};
      2'd2: bus.gen_imm = {{32{bus.gen_inst[31]}}, bus.gen_inst[31:12], 12'b0};
      default: bus.gen_imm = {{51{bus.gen_inst[31]}}, bus.gen_inst[31], bus.gen_inst[7],
                              bus.gen_inst[30:25], bus.gen_inst[11:8], 1'b0};
    endcase
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic apply(input vec_t v);
    rst = v.rst;
    bus.flush = v.flush;
    bus.req_valid = v.rv;
    bus.resp_ready = v.rr;
    bus.req_inst = {v.i1, v.i0};
    bus.req_imm_type = {v.t1, v.t0};
  endtask
  vec_t vt [22];
  initial begin
    vt[0]  = '{1, 0, 2'b11, 2'b00, IA, 2'd0, BB, 2'd3, 2'b00, 2'b00, 1, 64'd0, 1, 64'd0};
    vt[1]  = '{0, 0, 2'b01, 2'b00, IA, 2'd0, BB, 2'd3, 2'b01, 2'b01, 1, M1, 0, 64'd0};
    vt[2]  = '{0, 0, 2'b00, 2'b01, IA, 2'd0, BB, 2'd3, 2'b00, 2'b00, 0, 64'd0, 0, 64'd0};
    vt[3]  = '{1, 0, 2'b11, 2'b11, UA, 2'd2, BB, 2'd3, 2'b00, 2'b00, 0, 64'd0, 0, 64'd0};
    vt[4]  = '{0, 0, 2'b11, 2'b11, UA, 2'd2, BB, 2'd3, 2'b01, 2'b01, 1, MU, 0, 64'd0};
    vt[5]  = '{0, 0, 2'b11, 2'b11, UA, 2'd2, BB, 2'd3, 2'b10, 2'b10, 0, 64'd0, 1, MB};
    vt[6]  = '{0, 0, 2'b11, 2'b11, UA, 2'd2, BB, 2'd3, 2'b01, 2'b01, 1, MU, 0, 64'd0};
    vt[7]  = '{0, 0, 2'b11, 2'b11, UA, 2'd2, BB, 2'd3, 2'b10, 2'b10, 0, 64'd0, 1, MB};
    vt[8]  = '{0, 0, 2'b11, 2'b10, UA, 2'd2, BB, 2'd3, 2'b01, 2'b01, 1, MU, 0, 64'd0};
    vt[9]  = '{0, 0, 2'b11, 2'b10, IA, 2'd0, BB, 2'd3, 2'b10, 2'b11, 1, MU, 1, MB};
    vt[10] = '{0, 0, 2'b11, 2'b10, IA, 2'd0, BB, 2'd3, 2'b10, 2'b11, 1, MU, 1, MB};
    vt[11] = '{0, 0, 2'b11, 2'b10, IA, 2'd0, BB, 2'd3, 2'b10, 2'b11, 1, MU, 1, MB};
    vt[12] = '{0, 0, 2'b11, 2'b11, IA, 2'd0, BB, 2'd3, 2'b01, 2'b01, 1, M1, 0, 64'd0};
    vt[13] = '{0, 0, 2'b01, 2'b01, SA, 2'd1, BB, 2'd3, 2'b01, 2'b01, 1, MS, 0, 64'd0};
    vt[14] = '{0, 0, 2'b10, 2'b00, SA, 2'd1, BB, 2'd3, 2'b10, 2'b11, 1, MS, 1, MB};
    vt[15] = '{0, 0, 2'b11, 2'b01, SA, 2'd1, BB, 2'd3, 2'b01, 2'b11, 1, MS, 1, MB};
    vt[16] = '{0, 1, 2'b11, 2'b00, SA, 2'd1, BB, 2'd3, 2'b00, 2'b00, 0, 64'd0, 0, 64'd0};
    vt[17] = '{0, 0, 2'b11, 2'b00, SA, 2'd1, BB, 2'd3, 2'b10, 2'b10, 0, 64'd0, 1, MB};
    vt[18] = '{0, 0, 2'b11, 2'b11, UA, 2'd2, BB, 2'd3, 2'b01, 2'b01, 1, MU, 0, 64'd0};
    vt[19] = '{1, 0, 2'b11, 2'b11, UA, 2'd2, BB, 2'd3, 2'b00, 2'b00, 1, 64'd0, 1, 64'd0};
    vt[20] = '{0, 0, 2'b11, 2'b11, UA, 2'd2, BB, 2'd3, 2'b01, 2'b01, 1, MU, 0, 64'd0};
    vt[21] = '{0, 0, 2'b00, 2'b11, UA, 2'd2, BB, 2'd3, 2'b00, 2'b00, 0, 64'd0, 0, 64'd0};
    for (int n = 0; n < 22; n++) begin
      apply(vt[n]);
      #1;
      check($sformatf("row%0d req_ready", n), 64'(bus.req_ready), 64'(vt[n].exp_rdy));
      check($sformatf("row%0d gen_inst", n), 64'(bus.gen_inst),
            64'(vt[n].exp_rdy[0] ? vt[n].i0 : vt[n].exp_rdy[1] ? vt[n].i1 : 32'd0));
      check($sformatf("row%0d gen_imm_type", n), 64'(bus.gen_imm_type),
            64'(vt[n].exp_rdy[0] ? vt[n].t0 : vt[n].exp_rdy[1] ? vt[n].t1 : 2'd0));
      @(posedge clk);
      #1;
      check($sformatf("row%0d resp_valid", n), 64'(bus.resp_valid), 64'(vt[n].exp_vld));
      if (vt[n].c0) check($sformatf("row%0d resp_imm0", n), bus.resp_imm[63:0], vt[n].m0);
      if (vt[n].c1) check($sformatf("row%0d resp_imm1", n), bus.resp_imm[127:64], vt[n].m1);
    end
    // rst and flush together, then a lone request from requester 1
    apply('{1, 1, 2'b11, 2'b00, IA, 2'd0, SA, 2'd1, 2'b00, 2'b00, 0, 64'd0, 0, 64'd0});
    #1;
    check("rstflush req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rstflush resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rstflush resp_imm", bus.resp_imm[63:0] | bus.resp_imm[127:64], 64'd0);
    apply('{0, 0, 2'b10, 2'b00, IA, 2'd0, SA, 2'd1, 2'b00, 2'b00, 0, 64'd0, 0, 64'd0});
    #1;
    check("lone1 req_ready", 64'(bus.req_ready), 64'd2);
    check("lone1 gen_inst", 64'(bus.gen_inst), 64'(SA));
    @(posedge clk);
    #1;
    check("lone1 resp_valid", 64'(bus.resp_valid), 64'd2);
    check("lone1 resp_imm1", bus.resp_imm[127:64], MS);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
